// File: rtl/mux_scan_sel_pkg.sv
// Shared encodings and widths for the registered N-channel scan/manual selector.
package mux_scan_sel_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

endpackage

// File: rtl/mux_scan_sel_scan_ctr.sv
// Dwell counter and round-robin channel pointer; ch/wrap give the channel for the coming edge.
module scan_ctr
    import mux_scan_sel_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            load,
    input  logic [SELW-1:0] load_val,
    output logic [SELW-1:0] ch,
    output logic            wrap
);

    localparam logic [SELW-1:0]  LAST_CH  = SELW'(NCH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             fresh_q, fresh_d;
    logic             adv;

    // fresh_q marks a pointer that has not yet been emitted, so its first scan edge starts a full dwell
    always_comb begin
        adv     = run && !fresh_q && (cnt_q == LAST_CNT);
        ch      = ch_q;
        wrap    = 1'b0;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        fresh_d = fresh_q;
        if (adv) begin
            wrap = (ch_q == LAST_CH);
            ch   = (ch_q == LAST_CH) ? '0 : ch_q + SELW'(1);
        end
        if (load) begin
            cnt_d   = '0;
            ch_d    = load_val;
            fresh_d = 1'b1;
        end else if (run) begin
            fresh_d = 1'b0;
            ch_d    = ch;
            cnt_d   = (fresh_q || adv) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            ch_q    <= '0;
            fresh_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            fresh_q <= fresh_d;
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector: manual select or round-robin dwell scan, with channel tag.
module mux_scan_sel
    import mux_scan_sel_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel_in,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      ch_out,
    output logic                 y_valid,
    output logic                 sel_err,
    output logic                 scan_wrap
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    state_e           state_q, state_d;
    logic             sel_ok;
    logic [SELW-1:0]  load_val;
    logic             run_c, load_c;
    logic [SELW-1:0]  scan_ch;
    logic             scan_wrap_c;
    logic [SELW-1:0]  next_ch;
    logic [WIDTH-1:0] mux_y;

    logic [WIDTH-1:0] y_q, y_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    // Out-of-range selects only exist when the select space exceeds the channel count
    if (NCH < (32'd1 << SELW)) begin : g_sel_chk
        assign sel_ok = (sel_in <= LAST_CH);
    end else begin : g_sel_full
        assign sel_ok = 1'b1;
    end

    assign load_val = sel_ok ? sel_in : '0;

    always_comb begin
        state_d = ST_IDLE;
        if (en) begin
            state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        end
    end

    assign run_c  = (state_d == ST_SCAN);
    assign load_c = (state_d == ST_MANUAL);

    scan_ctr #(
        .NCH   (NCH),
        .SELW  (SELW),
        .DWELL (DWELL)
    ) u_scan_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run_c),
        .load     (load_c),
        .load_val (load_val),
        .ch       (scan_ch),
        .wrap     (scan_wrap_c)
    );

    always_comb begin
        next_ch = ch_q;
        mux_y   = '0;
        y_d     = y_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        case (state_d)
            ST_MANUAL: next_ch = sel_in;
            ST_SCAN:   next_ch = scan_ch;
            default:   next_ch = ch_q;
        endcase
        // Unmatched (out-of-range) index leaves mux_y at zero
        for (int unsigned k = 0; k < NCH; k++) begin
            if (next_ch == SELW'(k)) begin
                mux_y = din[k*WIDTH +: WIDTH];
            end
        end
        case (state_d)
            ST_MANUAL: begin
                y_d     = mux_y;
                ch_d    = sel_in;
                valid_d = sel_ok;
                err_d   = !sel_ok;
            end
            ST_SCAN: begin
                y_d     = mux_y;
                ch_d    = scan_ch;
                valid_d = 1'b1;
                wrap_d  = scan_wrap_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y         = y_q;
    assign ch_out    = ch_q;
    assign y_valid   = valid_q;
    assign sel_err   = err_q;
    assign scan_wrap = wrap_q;

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
Parametrised N-channel, W-bit registered channel selector. It is the clocked successor of the team's 4:1 structural selector.
- Manual mode: an external select picks the channel.
- Scan mode: an internal dwell counter steps through all channels round-robin and flags each wrap.
- Sits between parallel sensor/data lanes and a single downstream consumer that needs a registered, channel-tagged stream.

Parameters:
WIDTH, 1, bit width of each data channel
NCH, 4, number of input channels (2..16)
SELW, 2, select width; must satisfy 2**SELW >= NCH
DWELL, 4, cycles spent on each channel in scan mode (1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  NCH*WIDTH  packed channel data; channel k = din[k*WIDTH +: WIDTH]
en  input  1  block enable; 0 = idle/hold
mode  input  1  0 = manual, 1 = scan
sel_in  input  SELW  manual channel select
y  output  WIDTH  registered selected data
ch_out  output  SELW  channel index that y was taken from
y_valid  output  1  y/ch_out hold a fresh sample this cycle
sel_err  output  1  manual sel_in >= NCH was presented last cycle
scan_wrap  output  1  one-cycle pulse when scan steps from NCH-1 to 0

Behaviour:
- Reset (async, rst_n=0): y=0, ch_out=0, y_valid=0, sel_err=0, scan_wrap=0, dwell counter=0, state=IDLE. Release is synchronous to the next clk edge.
- States: IDLE, MANUAL, SCAN. Evaluated every edge:
  - en=0 -> IDLE.
  - en=1 & mode=0 -> MANUAL.
  - en=1 & mode=1 -> SCAN.
- IDLE: y and ch_out hold their last values; y_valid=0; sel_err=0; scan_wrap=0; dwell counter holds.
- next_ch is combinational; each active edge loads y <= din[next_ch], ch_out <= next_ch, y_valid <= 1. Latency: one cycle from sel_in/din change to y.
- MANUAL:
  - next_ch = sel_in; dwell counter cleared to 0.
  - If sel_in >= NCH: y <= 0, ch_out <= sel_in, y_valid <= 0, sel_err <= 1.
  - Otherwise sel_err <= 0.
- SCAN:
  - Dwell counter counts 0..DWELL-1.
  - When the counter = DWELL-1: next_ch = ch_out+1, wrapping NCH-1 -> 0, and the counter returns to 0.
  - Otherwise next_ch = ch_out.
  - scan_wrap=1 on exactly the edge where ch_out goes NCH-1 -> 0.
  - sel_in is ignored; sel_err=0.
- Mode change MANUAL->SCAN: scan starts from the current ch_out with a fresh dwell (the first dwell is full DWELL cycles). If ch_out >= NCH (error case), scan starts at 0.
- Mode change SCAN->MANUAL: takes effect on the same edge; the dwell counter is cleared.
- en drop mid-dwell: the counter freezes. On re-enable in SCAN, the dwell resumes with the remaining count.
- DWELL=1: the channel advances every active edge.
- NCH=2**SELW: no sel_err possible; wrap is natural.
- Counter width is 8 bits. All index arithmetic uses SELW bits with an explicit compare against NCH-1 (no reliance on overflow).

Decomposition:
- Shared package/header: mode encodings (MODE_MANUAL=0, MODE_SCAN=1) and state encodings (ST_IDLE, ST_MANUAL, ST_SCAN).
- One natural sub-module, scan_ctr: the dwell counter plus channel pointer with wrap pulse. Parameters NCH, SELW, DWELL; ports clk, rst_n, run, load, load_val, ch, wrap.
- The top level holds the state register, the mux, and the output registers.

Test Plan:
1. Reset then manual sweep: WIDTH=1, NCH=4, en=1, mode=0; step sel_in 0..3 with din=4'b1010 -> y follows din[sel_in] one cycle later (0,1,0,1), ch_out=sel_in, y_valid=1.
2. Exhaustive data: for every sel_in in 0..3 drive {din} = 0..15 on 10-cycle steps -> y equals bit sel_in of the din value from the previous edge, for all 64 combinations.
3. Scan timing: mode=1, DWELL=4, NCH=4 -> ch_out sequence 0000 1111 2222 3333 0...; scan_wrap high only on the edge ch_out 3->0 (once every 16 cycles).
4. Error select: NCH=3, SELW=2, sel_in=3 -> next cycle y=0, y_valid=0, sel_err=1; sel_in=1 -> sel_err clears next cycle.
5. Enable pause: in scan, drop en for 5 cycles after 2 dwell cycles on ch 1 -> y/ch_out hold, y_valid=0; after re-enable ch 1 persists 2 more cycles, then ch 2.
6. Async reset mid-scan: assert rst_n=0 between clock edges while ch_out=2 -> all outputs 0 immediately without a clock; after release, scan restarts at ch 0 with full dwell.
